// File: rtl/sys_bus_axil_bridge_if.sv
// sys_bus_if: single-master system bus. The master drives the address, write data and
// one-cycle wen/ren strobes. The addressed slave answers with ack or err and, for reads,
// with rdata.
interface sys_bus_if #(
    parameter int AW = 32
);
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          wen;
    logic          ren;
    logic [31:0]   rdata;
    logic          ack;
    logic          err;

    modport m (
        output addr, wdata, wen, ren,
        input  rdata, ack, err
    );

    modport s (
        input  addr, wdata, wen, ren,
        output rdata, ack, err
    );
endinterface

// File: rtl/sys_bus_axil_bridge.sv
// sys_bus_axil_bridge: AXI4-Lite slave to sys_bus master bridge.
// The bridge handles one transaction at a time. When a write and a read arrive together,
// they alternate under round-robin arbitration.
// Each accepted request becomes a single wen/ren pulse. The address and data stay held
// until the slave answers.
// Optional timeout: define SYS_BUS_AXIL_TIMEOUT_EN to bound the wait to TO_CYC cycles.
// A timed-out transaction completes with SLVERR, and a timed-out read returns zero data.
module sys_bus_axil_bridge #(
    parameter int AW     = 32,
    parameter int TO_CYC = 256
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] awaddr,
    input  logic          awvalid,
    output logic          awready,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          wvalid,
    output logic          wready,
    output logic [1:0]    bresp,
    output logic          bvalid,
    input  logic          bready,
    input  logic [AW-1:0] araddr,
    input  logic          arvalid,
    output logic          arready,
    output logic [31:0]   rdata,
    output logic [1:0]    rresp,
    output logic          rvalid,
    input  logic          rready,
    sys_bus_if.m          bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WPULSE,
        S_RPULSE,
        S_WAIT,
        S_BRESP,
        S_RRESP
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

    state_t        state_q, state_d;
    logic          pri_wr_q;   // 1: write wins the next contested grant
    logic          is_rd_q;    // kind of the transaction in flight
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          wr_req, rd_req;
    logic          grant_w, grant_r;
    logic          bus_done;   // slave answered or the timeout fired this cycle
    logic          to_fire;    // completion caused by the timeout
    logic          to_hit;

    function automatic logic [1:0] resp_enc(input logic e);
        return e ? 2'b10 : 2'b00;
    endfunction

    assign wr_req = awvalid && wvalid;
    assign rd_req = arvalid;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration, completion detection and next-state decode
    always_comb begin
        state_d  = state_q;
        grant_w  = 1'b0;
        grant_r  = 1'b0;
        bus_done = 1'b0;
        to_fire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_req && (!rd_req || pri_wr_q)) begin
                    grant_w = 1'b1;
                end else if (rd_req) begin
                    grant_r = 1'b1;
                end
                if (grant_w) begin
                    // Partial strobes are refused without touching the bus.
                    state_d = (wstrb == 4'hF) ? S_WPULSE : S_BRESP;
                end else if (grant_r) begin
                    state_d = S_RPULSE;
                end
            end
            S_WPULSE, S_RPULSE, S_WAIT: begin
                if (bus.ack || bus.err) begin
                    bus_done = 1'b1;
                end else if (to_hit) begin
                    bus_done = 1'b1;
                    to_fire  = 1'b1;
                end
                if (bus_done) begin
                    state_d = is_rd_q ? S_RRESP : S_BRESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_BRESP: begin
                if (bready) begin
                    state_d = S_IDLE;
                end
            end
            S_RRESP: begin
                if (rready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latching, round-robin pointer and response capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            is_rd_q  <= 1'b0;
            pri_wr_q <= 1'b1;
        end else begin
            if (grant_w) begin
                addr_q   <= awaddr;
                wdata_q  <= wdata;
                is_rd_q  <= 1'b0;
                pri_wr_q <= 1'b0;
                err_q    <= (wstrb != 4'hF);
            end else if (grant_r) begin
                addr_q   <= araddr;
                is_rd_q  <= 1'b1;
                pri_wr_q <= 1'b1;
            end
            if (bus_done) begin
                // err wins over a simultaneous ack. Read data is still taken from the slave.
                err_q <= bus.err || to_fire;
                if (is_rd_q) begin
                    rdata_q <= to_fire ? 32'h0 : bus.rdata;
                end
            end
        end
    end

`ifdef SYS_BUS_AXIL_TIMEOUT_EN
    logic [15:0] to_cnt_q;

    // Cycles spent waiting on the slave, restarted at every accept
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= '0;
        end else if (grant_w || grant_r) begin
            to_cnt_q <= '0;
        end else if (state_q == S_WPULSE || state_q == S_RPULSE || state_q == S_WAIT) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    assign to_hit = (to_cnt_q == TO_LAST);
`else
    logic unused_to;
    assign unused_to = ^TO_LAST;
    assign to_hit    = 1'b0;
`endif

    assign awready = grant_w;
    assign wready  = grant_w;
    assign arready = grant_r;

    assign bvalid  = (state_q == S_BRESP);
    assign rvalid  = (state_q == S_RRESP);
    assign bresp   = resp_enc(err_q);
    assign rresp   = resp_enc(err_q);
    assign rdata   = rdata_q;

    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.wen   = (state_q == S_WPULSE);
    assign bus.ren   = (state_q == S_RPULSE);

endmodule

// File: tb/tb_sys_bus_axil_bridge.sv
// Directed testbench for sys_bus_axil_bridge.
// The timeout scenario runs when SYS_BUS_AXIL_TIMEOUT_EN is defined; the DUT is built with TO_CYC=8.
module tb_sys_bus_axil_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    sys_bus_if #(.AW(32)) bus_if ();

    sys_bus_axil_bridge #(.AW(32), .TO_CYC(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with the DUT idle. The slave answers in cycle T+1+dly,
    // where T is the handshake edge; dly<0 means the slave stays silent.
    // Returns just after the edge that completes the response handshake.
    task automatic xact(input string tag, input bit is_wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] strb, input int dly,
                        input bit s_ack, input bit s_err, input logic [31:0] srd,
                        input int hold, input int exp_lat, input logic [1:0] exp_resp,
                        input logic [31:0] exp_rd);
        int got, nw, nr;
        got = -1; nw = 0; nr = 0;
        if (is_wr) begin
            awaddr = a; wdata = d; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = a; arvalid = 1'b1;
        end
        @(negedge clk);
        if (is_wr) begin
            chk({tag, ".awready"}, awready, 1'b1);
            chk({tag, ".wready"}, wready, 1'b1);
            chk({tag, ".arready"}, arready, 1'b0);
        end else begin
            chk({tag, ".arready"}, arready, 1'b1);
            chk({tag, ".awready"}, awready, 1'b0);
        end
        @(posedge clk); #1;
        if (is_wr) begin awvalid = 1'b0; wvalid = 1'b0; end
        else arvalid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            bus_if.ack   = (c - 1 == dly) && s_ack;
            bus_if.err   = (c - 1 == dly) && s_err;
            bus_if.rdata = (c - 1 == dly) ? srd : 32'hDEAD_BEEF;
            @(negedge clk);
            if (bus_if.wen) begin
                nw++;
                chk({tag, ".wen_addr"}, bus_if.addr, a);
                chk({tag, ".wen_wdata"}, bus_if.wdata, d);
            end
            if (bus_if.ren) begin
                nr++;
                chk({tag, ".ren_addr"}, bus_if.addr, a);
            end
            if (is_wr ? bvalid : rvalid) begin
                got = c;
                break;
            end
            @(posedge clk); #1;
        end
        bus_if.ack = 1'b0;
        bus_if.err = 1'b0;
        chk({tag, ".latency"}, got, exp_lat);
        chk({tag, ".wen_count"}, nw, (is_wr && strb == 4'hF) ? 1 : 0);
        chk({tag, ".ren_count"}, nr, is_wr ? 0 : 1);
        chk({tag, ".resp"}, is_wr ? bresp : rresp, exp_resp);
        if (!is_wr) chk({tag, ".rdata"}, rdata, exp_rd);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({tag, ".hold_valid"}, is_wr ? bvalid : rvalid, 1'b1);
            chk({tag, ".hold_resp"}, is_wr ? bresp : rresp, exp_resp);
            chk({tag, ".hold_addr"}, bus_if.addr, a);
            if (!is_wr) chk({tag, ".hold_rdata"}, rdata, exp_rd);
        end
        if (is_wr) bready = 1'b1;
        else rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        rready = 1'b0;
        chk({tag, ".valid_drop"}, is_wr ? bvalid : rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        bus_if.ack = 1'b0; bus_if.err = 1'b0; bus_if.rdata = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.bvalid", bvalid, 1'b0);
        chk("rst.rvalid", rvalid, 1'b0);
        chk("rst.wen", bus_if.wen, 1'b0);
        chk("rst.ren", bus_if.ren, 1'b0);
        chk("rst.addr", bus_if.addr, 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.bresp", bresp, 2'b00);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // zero-wait write
        xact("wr0", 1'b1, 32'h4010_0004, 32'h1234_5678, 4'hF, 0, 1'b1, 1'b0, 32'h0,
             0, 2, 2'b00, 32'h0);
        // read with 3 wait cycles, rready held low for 4 cycles
        xact("rd3", 1'b0, 32'h4020_0000, 32'h0, 4'h0, 3, 1'b1, 1'b0, 32'hCAFE_F00D,
             4, 5, 2'b00, 32'hCAFE_F00D);

        // contested requests: grant order W, R, W, then drain the last read
        araddr = 32'h4000_0100; arvalid = 1'b1;
        xact("arbW1", 1'b1, 32'h4000_0200, 32'h1111_2222, 4'hF, 1, 1'b1, 1'b0, 32'h0,
             0, 3, 2'b00, 32'h0);
        awaddr = 32'h4000_0300; wdata = 32'h3333_4444; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        xact("arbR2", 1'b0, 32'h4000_0100, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h0BAD_CAFE,
             0, 2, 2'b00, 32'h0BAD_CAFE);
        araddr = 32'h4000_0400; arvalid = 1'b1;
        xact("arbW3", 1'b1, 32'h4000_0300, 32'h3333_4444, 4'hF, 0, 1'b1, 1'b0, 32'h0,
             0, 2, 2'b00, 32'h0);
        xact("arbR4", 1'b0, 32'h4000_0400, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h5555_6666,
             0, 2, 2'b00, 32'h5555_6666);

        // partial strobe: refused, no bus access, slave ack in that window ignored
        xact("strb3", 1'b1, 32'h4010_0008, 32'hAAAA_BBBB, 4'h3, 0, 1'b1, 1'b0, 32'h0,
             2, 1, 2'b10, 32'h0);
        // slave err on a read: SLVERR, data still captured
        xact("rderr", 1'b0, 32'h4030_0000, 32'h0, 4'h0, 2, 1'b0, 1'b1, 32'h7777_8888,
             0, 4, 2'b10, 32'h7777_8888);
        // ack and err together on a write: err wins
        xact("wrackerr", 1'b1, 32'h4030_0010, 32'h0F0F_0F0F, 4'hF, 1, 1'b1, 1'b1, 32'h0,
             0, 3, 2'b10, 32'h0);

`ifdef SYS_BUS_AXIL_TIMEOUT_EN
        // silent slave: timeout gives SLVERR with zero data 8 cycles after the pulse
        xact("tmo", 1'b0, 32'h4040_0000, 32'h0, 4'h0, -1, 1'b0, 1'b0, 32'h0,
             0, 9, 2'b10, 32'h0);
        // late ack while idle must be ignored
        bus_if.ack = 1'b1; bus_if.rdata = 32'h1357_9BDF;
        @(negedge clk);
        chk("late.bvalid", bvalid, 1'b0);
        chk("late.rvalid", rvalid, 1'b0);
        @(posedge clk); #1;
        bus_if.ack = 1'b0;
        xact("post_tmo", 1'b0, 32'h4040_0004, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h9999_AAAA,
             0, 2, 2'b00, 32'h9999_AAAA);
`else
        // long slave wait without a timeout
        xact("wrlong", 1'b1, 32'h4040_0008, 32'h2468_ACE0, 4'hF, 6, 1'b1, 1'b0, 32'h0,
             0, 8, 2'b00, 32'h0);
`endif

        // reset while waiting on a silent slave
        araddr = 32'h4050_0000; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("mrst.rvalid", rvalid, 1'b0);
        chk("mrst.bvalid", bvalid, 1'b0);
        chk("mrst.ren", bus_if.ren, 1'b0);
        chk("mrst.wen", bus_if.wen, 1'b0);
        chk("mrst.addr", bus_if.addr, 32'h0);
        chk("mrst.wdata", bus_if.wdata, 32'h0);
        chk("mrst.rdata", rdata, 32'h0);
        chk("mrst.resp", {bresp, rresp}, 4'b0000);
        chk("mrst.arready", arready, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        xact("after_rst", 1'b1, 32'h4060_0000, 32'hFEED_BEEF, 4'hF, 0, 1'b1, 1'b0, 32'h0,
             0, 2, 2'b00, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_bus_axil_bridge.md
# sys_bus_axil_bridge

AXI4-Lite slave to `sys_bus` master bridge that sits directly upstream of the system bus interconnect and drives its `bus_m` port. It:
- accepts one AXI4-Lite read or write at a time;
- converts it into a single-cycle `wen`/`ren` pulse with held address and data;
- waits for `ack`/`err` from the addressed slave, bounded by an optional timeout;
- returns the AXI response.

Reads and writes are serialised with round-robin arbitration.

## Interface
Parameters:
- `AW`, 32, AXI and `sys_bus` address width.
- `TO_CYC`, 256, timeout in clock cycles; legal range is 2..65535. Used only when the timeout is compiled in.

Ports (clock and reset first):
- `clk`  in  1  bridge clock; the AXI port and the `sys_bus` master share it.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `awaddr`  in  AW  write address.
- `awvalid`  in  1  write address valid.
- `awready`  out  1  write address ready.
- `wdata`  in  32  write data.
- `wstrb`  in  4  write strobes.
- `wvalid`  in  1  write data valid.
- `wready`  out  1  write data ready.
- `bresp`  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- `bvalid`  out  1  write response valid.
- `bready`  in  1  write response ready.
- `araddr`  in  AW  read address.
- `arvalid`  in  1  read address valid.
- `arready`  out  1  read address ready.
- `rdata`  out  32  read data.
- `rresp`  out  2  read response.
- `rvalid`  out  1  read response valid.
- `rready`  in  1  read response ready.
- `bus`  `sys_bus_if.m`  —  master side of `sys_bus`:
  - driven: `addr`, `wdata`, `wen`, `ren`;
  - sampled: `rdata`, `ack`, `err`.

## Operation
States: IDLE, WPULSE, RPULSE, WAIT, BRESP, RRESP.

IDLE:
- `awready`=`wready`=1 when `awvalid`&&`wvalid`; `arready`=1 when `arvalid`.
- At most one channel is granted per cycle.
- Write and read together: grant goes to the opposite of the last served kind. After reset, write wins.
- Write accept:
  - latch `awaddr`, `wdata`, `wstrb`.
  - If `wstrb`!=4'hF: go to BRESP with SLVERR and no bus access.
  - Otherwise: go to WPULSE.
- Read accept: latch `araddr`, go to RPULSE.

WPULSE / RPULSE:
- `bus.wen` (resp. `bus.ren`)=1 for exactly this cycle.
- `bus.addr` and `bus.wdata` come from the latched values.
- `ack`/`err` are sampled in this cycle; if asserted, go straight to BRESP/RRESP. Otherwise go to WAIT.

WAIT:
- `wen`=`ren`=0; `addr`/`wdata` held.
- First cycle with `ack`||`err`: capture `bus.rdata` (reads only) and `err`, then go to BRESP/RRESP.

BRESP:
- `bvalid`=1; `bresp`=SLVERR if `err` was seen or a timeout occurred, else OKAY.
- Exit to IDLE on `bready`.

RRESP:
- `rvalid`=1; `rdata` is the captured value; `rresp` follows the same rule as `bresp`.
- Exit to IDLE on `rready`.

Error and stability rules:
- `ack` and `err` together: `err` wins, giving SLVERR. Read data is still captured.
- `bus.addr`, `bus.wdata`, `bresp`, `rresp` and `rdata` are stable from pulse through response handshake.
- `ack`/`err` outside PULSE/WAIT are ignored.

## Timing
- Write handshake at edge T; `wen` high in cycle T+1.
- Zero-wait slave (`ack` in T+1): `bvalid` rises at T+2, giving 2-cycle address-to-response latency.
- Each extra slave wait cycle adds 1 cycle.
- The next request can be accepted in the cycle after the B/R handshake completes; there is no back-to-back overlap.
- AXI outputs are registered; there is no combinational path from `bus.ack` to `bvalid`/`rvalid`.

Reset values:
- All `*ready`, `*valid`, `wen`, `ren` = 0.
- `addr`, `wdata`, `rdata` = 0.
- `bresp`, `rresp` = 2'b00.
- State = IDLE; round-robin pointer = write.

Reset mid-transaction aborts it immediately, with no response issued. The upstream AXI master is reset in the same domain.

## Configuration
- `SYS_BUS_AXIL_TIMEOUT_EN` defined:
  - A 16-bit counter is cleared at PULSE entry and increments in PULSE/WAIT.
  - If it reaches `TO_CYC`-1 with no `ack`/`err`, the transaction completes with SLVERR; reads return `rdata`=32'h0.
  - A late `ack` that arrives after the timeout is dropped.
- Not defined: no counter. WAIT lasts until `ack`/`err`, indefinitely.

## Test plan
- Write 0x4010_0004=0x1234_5678, `wstrb`=F, slave acks in the `wen` cycle:
  - `wen` pulses exactly 1 cycle with that `addr`/`wdata`;
  - `bvalid` arrives 2 cycles after handshake with `bresp`=00.
- Read 0x4020_0000, slave acks after 3 wait cycles with `rdata`=0xCAFE_F00D:
  - `rvalid` arrives 5 cycles after handshake with that data and `rresp`=00;
  - `rvalid` holds while `rready`=0 for 4 cycles.
- Write and read asserted together on three consecutive transactions: grant order is W, R, W.
- `wstrb`=4'h3: no `wen` pulse; `bresp`=10.
- Slave asserts `err`, or stays silent with TIMEOUT_EN and `TO_CYC`=8:
  - `err` case: SLVERR;
  - silent case: SLVERR on `rvalid` with `rdata`=0, 8 cycles after the pulse;
  - a late `ack` after that does not disturb the next transaction.
- `rstn` asserted in WAIT: all outputs reach reset values asynchronously; the first transaction after release completes normally.
